// File: rtl/axis_packet_scheduler.sv
// Round-robin packet scheduler: grants one pending requester at a time and streams
// a header word plus NUM_DATA_WORDS payload words onto an AXI-Stream link.
module axis_packet_scheduler #(
    parameter int MAGIC_WIDTH     = 16,
    parameter int MAGIC_START_BIT = 16,
    parameter int INDEX_WIDTH     = 5,
    parameter int INDEX_START_BIT = 10,
    parameter int NUM_DATA_WORDS  = 1,
    parameter int NUM_REQUESTERS  = 2
) (
    input  logic                                   auroraClk,
    input  logic                                   auroraReset,
    input  logic                                   newCycleStrobe,
    input  logic [MAGIC_WIDTH-1:0]                 headerMagic,
    input  logic [NUM_REQUESTERS-1:0]              reqValid,
    input  logic [NUM_REQUESTERS*INDEX_WIDTH-1:0]  reqIndex,
    input  logic [NUM_REQUESTERS*32*NUM_DATA_WORDS-1:0] reqData,
    output logic [NUM_REQUESTERS-1:0]              reqAck,
    output logic                                   TVALID,
    input  logic                                   TREADY,
    output logic                                   TLAST,
    output logic [31:0]                            TDATA,
    output logic                                   sentStrobe,
    output logic                                   allServed
);

    localparam int PTR_W     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int CNT_W     = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam int PAYLOAD_W = 32 * NUM_DATA_WORDS;
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQUESTERS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);
    localparam bit FIELD_OVERLAP =
        (INDEX_START_BIT < MAGIC_START_BIT + MAGIC_WIDTH) &&
        (MAGIC_START_BIT < INDEX_START_BIT + INDEX_WIDTH);
    localparam bit FIELD_OUTSIDE =
        (MAGIC_START_BIT + MAGIC_WIDTH > 32) || (INDEX_START_BIT + INDEX_WIDTH > 32);

    generate
        if (FIELD_OVERLAP || FIELD_OUTSIDE || NUM_DATA_WORDS < 1 || NUM_REQUESTERS < 1) begin : g_bad_params
            $error("axis_packet_scheduler: illegal header field layout or zero-sized parameter");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                    state_reg;
    logic                      tvalid_reg;
    logic                      tlast_reg;
    logic [31:0]               tdata_reg;
    logic [CNT_W-1:0]          word_cnt_reg;
    logic [NUM_REQUESTERS-1:0] served_mask_reg;
    logic [PTR_W-1:0]          rr_pointer_reg;
    logic [PTR_W-1:0]          granted_reg;
    logic [PAYLOAD_W-1:0]      payload_reg;
    logic [NUM_REQUESTERS-1:0] req_ack_reg;
    logic                      sent_strobe_reg;

    logic [NUM_REQUESTERS-1:0] eligible;
    logic [NUM_REQUESTERS-1:0] rotated;
    logic [PTR_W-1:0]          cand_idx [NUM_REQUESTERS];
    logic [INDEX_WIDTH-1:0]    req_index_arr [NUM_REQUESTERS];
    logic [PAYLOAD_W-1:0]      req_data_arr [NUM_REQUESTERS];
    logic                      grant_found;
    logic [PTR_W-1:0]          grant_idx;
    logic [NUM_REQUESTERS-1:0] grant_onehot;
    logic [31:0]               header_word;

    assign eligible = reqValid & ~served_mask_reg;

    // rotated[gi] is the eligibility of the requester gi steps above rrPointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_req
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] pos;
            assign sum  = {1'b0, rr_pointer_reg} + (PTR_W+1)'(gi);
            assign pos  = (sum >= (PTR_W+1)'(NUM_REQUESTERS)) ?
                          PTR_W'(sum - (PTR_W+1)'(NUM_REQUESTERS)) : sum[PTR_W-1:0];
            assign rotated[gi]       = eligible[pos];
            assign cand_idx[gi]      = pos;
            assign req_index_arr[gi] = reqIndex[gi*INDEX_WIDTH +: INDEX_WIDTH];
            assign req_data_arr[gi]  = reqData[gi*PAYLOAD_W +: PAYLOAD_W];
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!grant_found && rotated[i]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    assign grant_onehot = NUM_REQUESTERS'(1) << grant_idx;

    always_comb begin
        header_word = '0;
        header_word[MAGIC_START_BIT +: MAGIC_WIDTH] = headerMagic;
        header_word[INDEX_START_BIT +: INDEX_WIDTH] = req_index_arr[grant_idx];
    end

    always_ff @(posedge auroraClk or posedge auroraReset) begin
        if (auroraReset) begin
            state_reg       <= IDLE;
            tvalid_reg      <= 1'b0;
            tlast_reg       <= 1'b0;
            tdata_reg       <= '0;
            word_cnt_reg    <= '0;
            served_mask_reg <= '0;
            rr_pointer_reg  <= '0;
            granted_reg     <= '0;
            payload_reg     <= '0;
            req_ack_reg     <= '0;
            sent_strobe_reg <= 1'b0;
        end else begin
            req_ack_reg     <= '0;
            sent_strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!newCycleStrobe && grant_found) begin
                        granted_reg     <= grant_idx;
                        payload_reg     <= req_data_arr[grant_idx];
                        served_mask_reg <= served_mask_reg | grant_onehot;
                        req_ack_reg     <= grant_onehot;
                        tvalid_reg      <= 1'b1;
                        tlast_reg       <= 1'b0;
                        tdata_reg       <= header_word;
                        state_reg       <= HEADER;
                    end
                end
                HEADER: begin
                    if (TREADY) begin
                        state_reg    <= DATA;
                        word_cnt_reg <= '0;
                        tdata_reg    <= payload_reg[31:0];
                        payload_reg  <= payload_reg >> 32;
                        tlast_reg    <= (LAST_WORD == '0);
                    end
                end
                DATA: begin
                    if (TREADY) begin
                        if (word_cnt_reg == LAST_WORD) begin
                            state_reg       <= IDLE;
                            tvalid_reg      <= 1'b0;
                            tlast_reg       <= 1'b0;
                            tdata_reg       <= '0;
                            sent_strobe_reg <= 1'b1;
                            rr_pointer_reg  <= (granted_reg == LAST_REQ) ? '0 : granted_reg + 1'b1;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                            tdata_reg    <= payload_reg[31:0];
                            payload_reg  <= payload_reg >> 32;
                            tlast_reg    <= ((word_cnt_reg + 1'b1) == LAST_WORD);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // A new distribution cycle overrides any pointer update from a finishing packet
            if (newCycleStrobe) begin
                served_mask_reg <= '0;
                rr_pointer_reg  <= '0;
            end
        end
    end

    assign reqAck     = req_ack_reg;
    assign TVALID     = tvalid_reg;
    assign TLAST      = tlast_reg;
    assign TDATA      = tdata_reg;
    assign sentStrobe = sent_strobe_reg;
    assign allServed  = &served_mask_reg;

endmodule

// File: tb/tb_axis_packet_scheduler.sv
// Scoreboard bench for axis_packet_scheduler: two requesters, three payload words.
module tb_axis_packet_scheduler;

    localparam logic [95:0] D0   = {32'h0F1E2D3C, 32'h9ABCDEF0, 32'h12345678};
    localparam logic [95:0] D1   = {32'h00000001, 32'hDEADBEEF, 32'hCAFEBABE};
    localparam logic [31:0] HDR0 = 32'hA5A50C00;
    localparam logic [31:0] HDR1 = 32'hA5A57C00;

    logic         auroraClk = 1'b0;
    logic         auroraReset = 1'b1;
    logic         newCycleStrobe = 1'b0;
    logic [15:0]  headerMagic = 16'hA5A5;
    logic [1:0]   reqValid = 2'b00;
    logic [9:0]   reqIndex;
    logic [191:0] reqData;
    logic [1:0]   reqAck;
    logic         TVALID;
    logic         TREADY = 1'b1;
    logic         TLAST;
    logic [31:0]  TDATA;
    logic         sentStrobe;
    logic         allServed;

    int checks = 0;
    int errors = 0;
    int sent_cnt = 0;
    logic [32:0] beat_q [$];
    logic [1:0]  ack_q [$];
    logic [32:0] exp_beat;
    logic [1:0]  exp_ack;
    logic        stall_pend = 1'b0;
    logic [32:0] stall_val;

    axis_packet_scheduler #(
        .MAGIC_WIDTH(16), .MAGIC_START_BIT(16), .INDEX_WIDTH(5), .INDEX_START_BIT(10),
        .NUM_DATA_WORDS(3), .NUM_REQUESTERS(2)
    ) dut (
        .auroraClk(auroraClk), .auroraReset(auroraReset), .newCycleStrobe(newCycleStrobe),
        .headerMagic(headerMagic), .reqValid(reqValid), .reqIndex(reqIndex), .reqData(reqData),
        .reqAck(reqAck), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST), .TDATA(TDATA),
        .sentStrobe(sentStrobe), .allServed(allServed)
    );

    always #5 auroraClk = ~auroraClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge auroraClk);
        #1;
    endtask

    task automatic push_pkt(input logic [1:0] ack, input logic [31:0] hdr, input logic [95:0] data);
        ack_q.push_back(ack);
        beat_q.push_back({1'b0, hdr});
        for (int w = 0; w < 3; w++)
            beat_q.push_back({(w == 2), data[32*w +: 32]});
    endtask

    task automatic pulse_strobe();
        tick();
        newCycleStrobe = 1'b1;
        tick();
        newCycleStrobe = 1'b0;
    endtask

    task automatic wait_acks();
        int cyc = 0;
        while (ack_q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("ack_drain", ack_q.size(), 0);
    endtask

    task automatic wait_sent(input int n, input bit rand_ready);
        int target = sent_cnt + n;
        int cyc = 0;
        while (sent_cnt < target && cyc < 400) begin
            tick();
            if (rand_ready) TREADY = 1'($urandom_range(0, 1));
            cyc++;
        end
        TREADY = 1'b1;
        chk("sent_count", sent_cnt, target);
    endtask

    // Monitor: every handshake, ack and completion is checked against the scoreboard
    always @(negedge auroraClk) begin
        if (auroraReset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_tvalid_held", TVALID, 1);
                chk("stall_data_held", {TLAST, TDATA}, stall_val);
            end
            stall_pend = TVALID && !TREADY;
            stall_val  = {TLAST, TDATA};
            if (TVALID && TREADY) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected actual=%h required=none", {TLAST, TDATA});
                end else begin
                    exp_beat = beat_q.pop_front();
                    chk("beat", {TLAST, TDATA}, exp_beat);
                    $display("beat data=%h last=%b", TDATA, TLAST);
                end
            end
            if (reqAck != 2'b00) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual=%b required=none", reqAck);
                end else begin
                    exp_ack = ack_q.pop_front();
                    chk("ack", reqAck, exp_ack);
                    $display("grant ack=%b", reqAck);
                end
            end
            if (sentStrobe) begin
                sent_cnt++;
                $display("packet sent count=%0d", sent_cnt);
            end
        end
    end

    initial begin
        int s0;
        reqIndex = {5'd31, 5'd3};
        reqData  = {D1, D0};
        repeat (3) tick();
        @(negedge auroraClk);
        chk("rst_tvalid", TVALID, 0);
        chk("rst_tlast", TLAST, 0);
        chk("rst_tdata", TDATA, 0);
        chk("rst_ack", reqAck, 0);
        chk("rst_sent", sentStrobe, 0);
        chk("rst_allserved", allServed, 0);
        tick();
        auroraReset = 1'b0;

        // Basic packet; payload changes after the grant must not leak into it
        pulse_strobe();
        push_pkt(2'b01, HDR0, D0);
        reqValid = 2'b01;
        wait_acks();
        reqValid = 2'b00;
        reqData[95:0] = {3{32'hFFFF0000}};
        wait_sent(1, 1'b0);
        reqData[95:0] = D0;
        @(negedge auroraClk);
        chk("allserved_half", allServed, 0);

        // Round robin: req0 then req1, then no further grants
        pulse_strobe();
        push_pkt(2'b01, HDR0, D0);
        push_pkt(2'b10, HDR1, D1);
        reqValid = 2'b11;
        wait_sent(2, 1'b0);
        @(negedge auroraClk);
        chk("allserved_full", allServed, 1);
        repeat (10) tick();
        @(negedge auroraClk);
        chk("idle_after_all", TVALID, 0);
        reqValid = 2'b00;

        // Backpressure with random TREADY
        pulse_strobe();
        push_pkt(2'b10, HDR1, D1);
        reqValid = 2'b10;
        wait_sent(1, 1'b1);
        reqValid = 2'b00;

        // Strobe during DATA of req1
        pulse_strobe();
        push_pkt(2'b10, HDR1, D1);
        reqValid = 2'b10;
        wait_acks();
        newCycleStrobe = 1'b1;
        reqValid = 2'b11;
        push_pkt(2'b01, HDR0, D0);
        push_pkt(2'b10, HDR1, D1);
        tick();
        newCycleStrobe = 1'b0;
        wait_sent(3, 1'b0);
        @(negedge auroraClk);
        chk("allserved_after_mid", allServed, 1);

        // Strobe and requests together in IDLE
        tick();
        newCycleStrobe = 1'b1;
        push_pkt(2'b01, HDR0, D0);
        push_pkt(2'b10, HDR1, D1);
        tick();
        newCycleStrobe = 1'b0;
        @(negedge auroraClk);
        chk("simul_no_ack", reqAck, 0);
        chk("simul_no_tvalid", TVALID, 0);
        chk("simul_mask_clear", allServed, 0);
        wait_sent(2, 1'b0);
        reqValid = 2'b00;

        // Reset while the header is stalled
        pulse_strobe();
        TREADY = 1'b0;
        ack_q.push_back(2'b01);
        reqValid = 2'b01;
        wait_acks();
        chk("stalled_tvalid", TVALID, 1);
        s0 = sent_cnt;
        #2 auroraReset = 1'b1;
        #1;
        chk("rstmid_tvalid", TVALID, 0);
        chk("rstmid_tdata", TDATA, 0);
        chk("rstmid_allserved", allServed, 0);
        reqValid = 2'b00;
        tick();
        tick();
        auroraReset = 1'b0;
        TREADY = 1'b1;
        repeat (3) tick();
        chk("rstmid_no_sent", sent_cnt, s0);
        push_pkt(2'b01, HDR0, D0);
        push_pkt(2'b10, HDR1, D1);
        reqValid = 2'b11;
        wait_sent(2, 1'b0);
        reqValid = 2'b00;

        repeat (5) tick();
        chk("beat_q_empty", beat_q.size(), 0);
        chk("ack_q_empty", ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
